// File: rtl/neuron_scheduler.sv
// Time-multiplexes one shared combinational neuron over the 3-neuron net (N1,N2 -> N3); 4 cycles accept-to-valid_out.
// Single sample in flight: ready only in IDLE, y held in OUT until ready_out. Optional SCHED_PERF_CNT_EN adds perf counters.
module neuron_scheduler #(
  parameter logic [31:0]        N1_W    = 32'h1097018D,
  parameter logic [31:0]        N2_W    = 32'hC820EA67,
  parameter logic [31:0]        N3_W    = 32'h5CDAAB4B,
  parameter logic signed [15:0] N1_BIAS = 16'sd12571,
  parameter logic signed [15:0] N2_BIAS = -16'sd8139,
  parameter logic signed [15:0] N3_BIAS = 16'sd10182,
  parameter logic signed [11:0] XMIN    = -12'sd127,
  parameter logic signed [11:0] XMAX    = 12'sd127
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        valid,
  output logic        ready,
  input  logic [31:0] x,
  output logic        valid_out,
  input  logic        ready_out,
  output logic [7:0]  y,
  output logic        busy,
  output logic [31:0] nrn_x,
  output logic [31:0] nrn_w,
  output logic [15:0] nrn_bias,
  output logic [11:0] nrn_xmin,
  output logic [11:0] nrn_xmax,
  input  logic [7:0]  nrn_y
`ifdef SCHED_PERF_CNT_EN
  ,
  output logic [15:0] infer_cnt,
  output logic [15:0] stall_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    L1A  = 3'd1,
    L1B  = 3'd2,
    L2   = 3'd3,
    OUT  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  s1_q, s1_d;
  logic [7:0]  y_q, y_d;
  logic [31:0] nrn_x_q, nrn_x_d;
  logic [31:0] nrn_w_q, nrn_w_d;
  logic [15:0] nrn_bias_q, nrn_bias_d;
  logic [11:0] nrn_xmin_q, nrn_xmin_d;
  logic [11:0] nrn_xmax_q, nrn_xmax_d;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= IDLE;
      s1_q       <= '0;
      y_q        <= '0;
      nrn_x_q    <= '0;
      nrn_w_q    <= '0;
      nrn_bias_q <= '0;
      nrn_xmin_q <= '0;
      nrn_xmax_q <= '0;
    end else begin
      state_q    <= state_d;
      s1_q       <= s1_d;
      y_q        <= y_d;
      nrn_x_q    <= nrn_x_d;
      nrn_w_q    <= nrn_w_d;
      nrn_bias_q <= nrn_bias_d;
      nrn_xmin_q <= nrn_xmin_d;
      nrn_xmax_q <= nrn_xmax_d;
    end
  end

  // The captured sample stays in nrn_x through L1B, and S2 lives in nrn_x[15:8]
  // from L2 onward, so neither needs a separate register.
  always_comb begin
    state_d    = state_q;
    s1_d       = s1_q;
    y_d        = y_q;
    nrn_x_d    = nrn_x_q;
    nrn_w_d    = nrn_w_q;
    nrn_bias_d = nrn_bias_q;
    nrn_xmin_d = nrn_xmin_q;
    nrn_xmax_d = nrn_xmax_q;
    case (state_q)
      IDLE: begin
        if (valid) begin
          nrn_x_d    = x;
          nrn_w_d    = N1_W;
          nrn_bias_d = N1_BIAS;
          nrn_xmin_d = XMIN;
          nrn_xmax_d = XMAX;
          state_d    = L1A;
        end
      end
      L1A: begin
        s1_d       = nrn_y;
        nrn_w_d    = N2_W;
        nrn_bias_d = N2_BIAS;
        state_d    = L1B;
      end
      L1B: begin
        nrn_x_d    = {8'h00, 8'h00, nrn_y, s1_q};
        nrn_w_d    = N3_W;
        nrn_bias_d = N3_BIAS;
        state_d    = L2;
      end
      L2: begin
        y_d     = nrn_y;
        state_d = OUT;
      end
      OUT: begin
        if (ready_out) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready     = (state_q == IDLE);
  assign valid_out = (state_q == OUT);
  assign busy      = (state_q != IDLE);
  assign y         = y_q;
  assign nrn_x     = nrn_x_q;
  assign nrn_w     = nrn_w_q;
  assign nrn_bias  = nrn_bias_q;
  assign nrn_xmin  = nrn_xmin_q;
  assign nrn_xmax  = nrn_xmax_q;

`ifdef SCHED_PERF_CNT_EN
  logic [15:0] infer_cnt_q, infer_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    infer_cnt_d = infer_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (state_q == OUT && ready_out && infer_cnt_q != 16'hFFFF)
      infer_cnt_d = infer_cnt_q + 16'd1;
    if (state_q == OUT && !ready_out && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      infer_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      infer_cnt_q <= infer_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign infer_cnt = infer_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_neuron_scheduler.sv
// Directed bench for neuron_scheduler; the neuron is a stub returning scripted results keyed on nrn_w.
module tb_neuron_scheduler;
  localparam logic [31:0] N1_W = 32'h1097018D;
  localparam logic [31:0] N2_W = 32'hC820EA67;
  localparam logic [31:0] N3_W = 32'h5CDAAB4B;

  logic        clk = 1'b0;
  logic        arst_n = 1'b1;
  logic        valid = 1'b0;
  logic        ready;
  logic [31:0] x = '0;
  logic        valid_out;
  logic        ready_out = 1'b0;
  logic [7:0]  y;
  logic        busy;
  logic [31:0] nrn_x, nrn_w;
  logic [15:0] nrn_bias;
  logic [11:0] nrn_xmin, nrn_xmax;
  logic [7:0]  nrn_y;
`ifdef SCHED_PERF_CNT_EN
  logic [15:0] infer_cnt, stall_cnt;
`endif

  logic [7:0] sy1 = 8'd0, sy2 = 8'd0, sy3 = 8'd0;
  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign nrn_y = (nrn_w == N1_W) ? sy1 :
                 (nrn_w == N2_W) ? sy2 :
                 (nrn_w == N3_W) ? sy3 : 8'h00;

  neuron_scheduler dut (
    .clk(clk), .arst_n(arst_n), .valid(valid), .ready(ready), .x(x),
    .valid_out(valid_out), .ready_out(ready_out), .y(y), .busy(busy),
    .nrn_x(nrn_x), .nrn_w(nrn_w), .nrn_bias(nrn_bias),
    .nrn_xmin(nrn_xmin), .nrn_xmax(nrn_xmax), .nrn_y(nrn_y)
`ifdef SCHED_PERF_CNT_EN
    , .infer_cnt(infer_cnt), .stall_cnt(stall_cnt)
`endif
  );

  task automatic do_reset();
    @(negedge clk);
    arst_n = 1'b0; valid = 1'b0; ready_out = 1'b0; x = '0;
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
  endtask

  // Waits (bounded) for ready at a falling edge, then presents x for one accepting edge.
  task automatic accept(input logic [31:0] xv, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready) begin ok = 1'b1; break; end
    end
    if (ok) begin
      x = xv; valid = 1'b1;
      @(posedge clk);
      #1 valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    arst_n = 1'b0;
    #1;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ready); end
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid_out got=%b exp=0", valid_out); end
    total++; if (y !== 8'h00) begin bad++; $display("FAIL reset_y got=%h exp=00", y); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (nrn_x !== 32'h0) begin bad++; $display("FAIL reset_nrn_x got=%h exp=0", nrn_x); end
    total++; if ({nrn_w, nrn_bias, nrn_xmin, nrn_xmax} !== 72'h0) begin bad++; $display("FAIL reset_nrn_ops got=%h exp=0", {nrn_w, nrn_bias, nrn_xmin, nrn_xmax}); end
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    sy1 = 8'd10; sy2 = -8'sd20; sy3 = 8'd55; ready_out = 1'b1;
    accept(32'h04030201, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_accept got=timeout exp=ready"); end
    @(negedge clk);
    total++; if (nrn_x !== 32'h04030201) begin bad++; $display("FAIL single_l1a_x got=%h exp=04030201", nrn_x); end
    total++; if (nrn_w !== N1_W || nrn_bias !== 16'h311B) begin bad++; $display("FAIL single_l1a_wb got=%h/%h exp=%h/311b", nrn_w, nrn_bias, N1_W); end
    total++; if (nrn_xmin !== 12'hF81 || nrn_xmax !== 12'h07F) begin bad++; $display("FAIL single_clamp got=%h/%h exp=f81/07f", nrn_xmin, nrn_xmax); end
    total++; if (busy !== 1'b1 || ready !== 1'b0) begin bad++; $display("FAIL single_busy got=%b%b exp=10", busy, ready); end
    @(negedge clk);
    total++; if (nrn_x !== 32'h04030201) begin bad++; $display("FAIL single_l1b_x got=%h exp=04030201", nrn_x); end
    total++; if (nrn_w !== N2_W || nrn_bias !== 16'hE035) begin bad++; $display("FAIL single_l1b_wb got=%h/%h exp=%h/e035", nrn_w, nrn_bias, N2_W); end
    @(negedge clk);
    total++; if (nrn_x !== 32'h0000EC0A) begin bad++; $display("FAIL single_l2_x got=%h exp=0000ec0a", nrn_x); end
    total++; if (nrn_w !== N3_W || nrn_bias !== 16'h27C6) begin bad++; $display("FAIL single_l2_wb got=%h/%h exp=%h/27c6", nrn_w, nrn_bias, N3_W); end
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL single_early_vo got=%b exp=0", valid_out); end
    @(negedge clk);
    total++; if (valid_out !== 1'b1 || y !== 8'h37) begin bad++; $display("FAIL single_out got=%b/%h exp=1/37", valid_out, y); end
    @(negedge clk);
    total++; if (valid_out !== 1'b0 || ready !== 1'b1 || y !== 8'h37) begin bad++; $display("FAIL single_idle got=%b%b/%h exp=01/37", valid_out, ready, y); end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    sy1 = 8'd10; sy2 = -8'sd20; sy3 = 8'd55; ready_out = 1'b0;
    accept(32'h04030201, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_accept got=timeout exp=ready"); end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++; if (valid_out !== 1'b1 || y !== 8'h37) begin bad++; $display("FAIL bp_hold%0d got=%b/%h exp=1/37", i, valid_out, y); end
    end
    @(posedge clk);
    #1 ready_out = 1'b1;
    @(negedge clk);
    total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL bp_release got=%b exp=1", valid_out); end
`ifdef SCHED_PERF_CNT_EN
    total++; if (stall_cnt !== 16'd6) begin bad++; $display("FAIL bp_stall_cnt got=%0d exp=6", stall_cnt); end
`endif
    @(negedge clk);
    total++; if (ready !== 1'b1 || valid_out !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL bp_idle got=%b%b%b exp=100", ready, valid_out, busy); end
`ifdef SCHED_PERF_CNT_EN
    total++; if (infer_cnt !== 16'd1) begin bad++; $display("FAIL bp_infer_cnt got=%0d exp=1", infer_cnt); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] samp [3];
    int t [3];
    bit ok;
    samp[0] = 32'h01020304; samp[1] = 32'hF0E0D0C0; samp[2] = 32'h7F80017E;
    do_reset();
    sy1 = 8'd10; sy2 = -8'sd20; sy3 = 8'd55; ready_out = 1'b1; valid = 1'b1;
    for (int s = 0; s < 3; s++) begin
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (ready) begin ok = 1'b1; break; end
        @(negedge clk);
      end
      total++; if (!ok) begin bad++; $display("FAIL b2b_wait%0d got=timeout exp=ready", s); end
      t[s] = cyc;
      x = samp[s];
      @(posedge clk);
      #1 x = 32'hDEADBEEF;
      if (s == 2) valid = 1'b0;
      @(negedge clk);
      total++; if (nrn_x !== samp[s]) begin bad++; $display("FAIL b2b_l1a%0d got=%h exp=%h", s, nrn_x, samp[s]); end
      @(negedge clk);
      total++; if (nrn_x !== samp[s]) begin bad++; $display("FAIL b2b_l1b%0d got=%h exp=%h", s, nrn_x, samp[s]); end
    end
    total++; if (t[1] - t[0] != 5) begin bad++; $display("FAIL b2b_gap01 got=%0d exp=5", t[1] - t[0]); end
    total++; if (t[2] - t[1] != 5) begin bad++; $display("FAIL b2b_gap12 got=%0d exp=5", t[2] - t[1]); end
    repeat (2) @(negedge clk);
    total++; if (valid_out !== 1'b1 || y !== 8'h37) begin bad++; $display("FAIL b2b_out got=%b/%h exp=1/37", valid_out, y); end
    @(negedge clk);
  endtask

  task automatic test_abort();
    bit ok;
    bit seen;
    do_reset();
    sy1 = 8'd10; sy2 = -8'sd20; sy3 = 8'd55; ready_out = 1'b1;
    accept(32'h11223344, ok);
    total++; if (!ok) begin bad++; $display("FAIL abort_accept got=timeout exp=ready"); end
    repeat (2) @(negedge clk);
    arst_n = 1'b0;
    #1;
    total++; if (ready !== 1'b1 || busy !== 1'b0 || valid_out !== 1'b0) begin bad++; $display("FAIL abort_state got=%b%b%b exp=100", ready, busy, valid_out); end
    total++; if (nrn_x !== 32'h0 || nrn_w !== 32'h0 || y !== 8'h00) begin bad++; $display("FAIL abort_zero got=%h/%h/%h exp=0/0/0", nrn_x, nrn_w, y); end
    #2 arst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (valid_out) seen = 1'b1;
    end
    total++; if (seen) begin bad++; $display("FAIL abort_no_output got=valid_out exp=none"); end
    sy1 = 8'd7; sy2 = -8'sd3; sy3 = -8'sd100;
    accept(32'h80FF7F01, ok);
    total++; if (!ok) begin bad++; $display("FAIL abort_accept2 got=timeout exp=ready"); end
    repeat (2) @(negedge clk);
    total++; if (nrn_x !== 32'h80FF7F01) begin bad++; $display("FAIL abort_l1b_x got=%h exp=80ff7f01", nrn_x); end
    @(negedge clk);
    total++; if (nrn_x !== 32'h0000FD07) begin bad++; $display("FAIL abort_l2_x got=%h exp=0000fd07", nrn_x); end
    @(negedge clk);
    total++; if (valid_out !== 1'b1 || y !== 8'h9C) begin bad++; $display("FAIL abort_out got=%b/%h exp=1/9c", valid_out, y); end
    @(negedge clk);
  endtask

`ifdef SCHED_PERF_CNT_EN
  task automatic test_saturation();
    bit ok;
    do_reset();
    sy1 = 8'd10; sy2 = -8'sd20; sy3 = 8'd55; ready_out = 1'b1;
    force dut.infer_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.infer_cnt_q;
    for (int s = 0; s < 2; s++) begin
      accept(32'h04030201, ok);
      total++; if (!ok) begin bad++; $display("FAIL sat_accept%0d got=timeout exp=ready", s); end
      repeat (5) @(negedge clk);
      total++; if (infer_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_infer%0d got=%h exp=ffff", s, infer_cnt); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_abort();
`ifdef SCHED_PERF_CNT_EN
    test_saturation();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
